// File: rtl/pcie_arb_pkg.sv
// rtl/pcie_arb_pkg.sv - shared constants for the virtual-channel arbiter
// Contents: VC count, destination-field position for the default 12-bit word,
// counter read index limit and the arbiter FSM state encodings.
package pcie_arb_pkg;

    localparam int NUM_VC   = 4;
    localparam int DEST_MSB = 11;
    localparam int DEST_LSB = 10;

    // idx values at or above this read back as invalid
    localparam logic [2:0] IDX_LIMIT = 3'd4;

    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_INIT   = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

endpackage

// File: rtl/controlador_arbitro_vc_rr_select.sv
// rtl/controlador_arbitro_vc_rr_select.sv - combinational round-robin picker
// Ports: eligible (request mask), ptr (first index to consider),
//        grant (one-hot winner), valid (any request present).
module rr_select
    import pcie_arb_pkg::*;
(
    input  logic [NUM_VC-1:0] eligible,
    input  logic [1:0]        ptr,
    output logic [NUM_VC-1:0] grant,
    output logic              valid
);

    // Scan offsets from farthest to nearest so the nearest eligible VC at or
    // after ptr is the last one written and therefore wins.
    always_comb begin
        grant = '0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            if (eligible[ptr + 2'(k)]) begin
                grant                = '0;
                grant[ptr + 2'(k)]   = 1'b1;
            end
        end
        valid = |eligible;
    end

endmodule

// File: rtl/controlador_arbitro_vc.sv
// rtl/controlador_arbitro_vc.sv - arbitrates four source VCs onto the destination word path
// Ports: clk/reset (sync, active-high); umbral_L_cfg/umbral_H_cfg latched in INIT
//        and driven out on umbral_L/umbral_H; vc_empty/data_vc describe source heads;
//        dest_almost_full gates destinations; pop (comb) / push + data_out (registered);
//        idle; req/idx -> contador/contador_valid per-destination word counter reads.
// Optional build macro PRIORIDAD_VC0_EN: VC0 has strict priority, round-robin over VC1..VC3.
module controlador_arbitro_vc
    import pcie_arb_pkg::*;
#(
    parameter int TAMANO_DATOS = 12,
    parameter int UMBRALES_L_H = 8,
    parameter int CONTADOR_W   = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [UMBRALES_L_H-1:0]        umbral_L_cfg,
    input  logic [UMBRALES_L_H-1:0]        umbral_H_cfg,
    input  logic [NUM_VC-1:0]              vc_empty,
    input  logic [NUM_VC*TAMANO_DATOS-1:0] data_vc,
    input  logic [NUM_VC-1:0]              dest_almost_full,
    output logic [NUM_VC-1:0]              pop,
    output logic [NUM_VC-1:0]              push,
    output logic [TAMANO_DATOS-1:0]        data_out,
    output logic [UMBRALES_L_H-1:0]        umbral_L,
    output logic [UMBRALES_L_H-1:0]        umbral_H,
    output logic                           idle,
    input  logic                           req,
    input  logic [2:0]                     idx,
    output logic [CONTADOR_W-1:0]          contador,
    output logic                           contador_valid
);

    logic [1:0]              state;
    logic [1:0]              ptr;
    logic [CONTADOR_W-1:0]   cnt [NUM_VC];
    logic [NUM_VC-1:0]       eligible;
    logic [NUM_VC-1:0]       rr_mask;
    logic [NUM_VC-1:0]       rr_grant;
    logic                    rr_valid;
    logic [NUM_VC-1:0]       grant;
    logic                    any_grant;
    logic [1:0]              gidx;
    logic [TAMANO_DATOS-1:0] gword;
    logic [NUM_VC-1:0]       push_nxt;
    logic                    running;

    assign running = (state == ST_IDLE) || (state == ST_ACTIVE);
    assign idle    = (state == ST_IDLE);

    // A VC only competes when its head word could actually be accepted.
    always_comb begin
        eligible = '0;
        for (int n = 0; n < NUM_VC; n++) begin
            eligible[n] = !vc_empty[n] &&
                !dest_almost_full[data_vc[n*TAMANO_DATOS + TAMANO_DATOS - 2 +: 2]];
        end
    end

`ifdef PRIORIDAD_VC0_EN
    assign rr_mask   = eligible & 4'b1110;
    assign grant     = eligible[0] ? 4'b0001 : rr_grant;
    assign any_grant = eligible[0] | rr_valid;
`else
    assign rr_mask   = eligible;
    assign grant     = rr_grant;
    assign any_grant = rr_valid;
`endif

    rr_select u_rr_select (
        .eligible (rr_mask),
        .ptr      (ptr),
        .grant    (rr_grant),
        .valid    (rr_valid)
    );

    always_comb begin
        gidx = '0;
        for (int n = 0; n < NUM_VC; n++) begin
            if (grant[n]) gidx = 2'(n);
        end
    end

    assign gword = data_vc[gidx*TAMANO_DATOS +: TAMANO_DATOS];
    assign pop   = (running && any_grant) ? grant : '0;

    always_comb begin
        push_nxt = '0;
        if (running && any_grant) push_nxt[gword[TAMANO_DATOS-1 -: 2]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_RESET;
            ptr            <= '0;
            push           <= '0;
            data_out       <= '0;
            umbral_L       <= '0;
            umbral_H       <= '0;
            contador       <= '0;
            contador_valid <= 1'b0;
            for (int d = 0; d < NUM_VC; d++) cnt[d] <= '0;
        end else begin
            case (state)
                ST_RESET: state <= ST_INIT;
                ST_INIT: begin
                    umbral_L <= umbral_L_cfg;
                    umbral_H <= umbral_H_cfg;
                    state    <= ST_IDLE;
                end
                default:  state <= any_grant ? ST_ACTIVE : ST_IDLE;
            endcase

            push <= push_nxt;
            if (running && any_grant) begin
                data_out <= gword;
`ifdef PRIORIDAD_VC0_EN
                // VC0 grants bypass the rotation, so they leave the pointer alone
                if (!grant[0]) ptr <= gidx + 2'd1;
`else
                ptr <= gidx + 2'd1;
`endif
            end

            for (int d = 0; d < NUM_VC; d++) begin
                if (push[d]) cnt[d] <= cnt[d] + 1'b1;
            end

            // cnt is sampled before this edge's increment lands
            if (!running) begin
                contador_valid <= 1'b0;
            end else if (req) begin
                if (idx < IDX_LIMIT) begin
                    contador       <= cnt[idx[1:0]];
                    contador_valid <= 1'b1;
                end else begin
                    contador       <= '0;
                    contador_valid <= 1'b0;
                end
            end else begin
                contador_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_controlador_arbitro_vc.sv
// tb/tb_controlador_arbitro_vc.sv - self-checking bench for controlador_arbitro_vc
module tb_controlador_arbitro_vc;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  umbral_L_cfg, umbral_H_cfg;
    logic [3:0]  vc_empty;
    logic [47:0] data_vc;
    logic [3:0]  dest_almost_full;
    logic [3:0]  pop, push;
    logic [11:0] data_out;
    logic [7:0]  umbral_L, umbral_H;
    logic        idle;
    logic        req;
    logic [2:0]  idx;
    logic [4:0]  contador;
    logic        contador_valid;

    always #5 clk = ~clk;

    controlador_arbitro_vc dut (
        .clk              (clk),
        .reset            (reset),
        .umbral_L_cfg     (umbral_L_cfg),
        .umbral_H_cfg     (umbral_H_cfg),
        .vc_empty         (vc_empty),
        .data_vc          (data_vc),
        .dest_almost_full (dest_almost_full),
        .pop              (pop),
        .push             (push),
        .data_out         (data_out),
        .umbral_L         (umbral_L),
        .umbral_H         (umbral_H),
        .idle             (idle),
        .req              (req),
        .idx              (idx),
        .contador         (contador),
        .contador_valid   (contador_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase -1 unknown, 0 reset, 1 init, 2 running
    int          phase = -1;
    int          m_ptr = 0;
    int          m_cnt [4];
    logic [3:0]  m_push = 4'b0;
    logic [11:0] m_data = 12'h0;
    logic [4:0]  m_cont = 5'h0;
    logic        m_cval = 1'b0;
    logic        m_idle = 1'b0;
    logic [7:0]  m_ul = 8'h0, m_uh = 8'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] el, input int p);
        int r;
        r = -1;
        for (int k = 0; k < 4; k++) begin
            if (r < 0 && el[(p + k) % 4]) r = (p + k) % 4;
        end
        return r;
    endfunction

    // One clock: check pop before the edge, advance the model, check registered outputs after.
    task automatic step();
        logic [3:0]  el;
        logic [11:0] w;
        int          g;
        for (int n = 0; n < 4; n++) begin
            w     = data_vc[n*12 +: 12];
            el[n] = !vc_empty[n] && !dest_almost_full[w[11:10]];
        end
        g = -1;
        if (phase == 2) begin
`ifdef PRIORIDAD_VC0_EN
            if (el[0]) g = 0;
            else       g = pick(el & 4'b1110, m_ptr);
`else
            g = pick(el, m_ptr);
`endif
        end
        #1;
        if (phase >= 0) chk("pop", pop, (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge clk);
        if (reset) begin
            phase  = 0;
            m_ptr  = 0;
            for (int d = 0; d < 4; d++) m_cnt[d] = 0;
            m_push = 4'b0;
            m_data = 12'h0;
            m_cont = 5'h0;
            m_cval = 1'b0;
            m_ul   = 8'h0;
            m_uh   = 8'h0;
            m_idle = 1'b0;
        end else begin
            if (phase == 2 && req) begin
                if (idx < 3'd4) begin
                    m_cont = 5'(m_cnt[idx]);
                    m_cval = 1'b1;
                end else begin
                    m_cont = 5'h0;
                    m_cval = 1'b0;
                end
            end else begin
                m_cval = 1'b0;
            end
            for (int d = 0; d < 4; d++) if (m_push[d]) m_cnt[d] = (m_cnt[d] + 1) % 32;
            if (g >= 0) begin
                w      = data_vc[g*12 +: 12];
                m_push = 4'b0;
                m_push[w[11:10]] = 1'b1;
                m_data = w;
`ifdef PRIORIDAD_VC0_EN
                if (g != 0) m_ptr = (g + 1) % 4;
`else
                m_ptr = (g + 1) % 4;
`endif
            end else begin
                m_push = 4'b0;
            end
            m_idle = (phase == 1) || (phase == 2 && g < 0);
            if (phase == 1) begin
                m_ul = umbral_L_cfg;
                m_uh = umbral_H_cfg;
            end
            phase = (phase == 0) ? 1 : 2;
        end
        #1;
        chk("push", push, m_push);
        chk("data_out", data_out, m_data);
        chk("idle", idle, m_idle);
        chk("contador", contador, m_cont);
        chk("contador_valid", contador_valid, m_cval);
        chk("umbral_L", umbral_L, m_ul);
        chk("umbral_H", umbral_H, m_uh);
        @(negedge clk);
    endtask

    initial begin
        reset            = 1'b1;
        umbral_L_cfg     = 8'd1;
        umbral_H_cfg     = 8'd6;
        vc_empty         = 4'hF;
        data_vc          = '0;
        dest_almost_full = 4'h0;
        req              = 1'b0;
        idx              = 3'd0;
        @(negedge clk);
        step();
        step();
        chk("rst_push", push, 4'b0);
        chk("rst_idle", idle, 1'b0);

        // Leave reset: RESET -> INIT -> IDLE, thresholds latched
        reset = 1'b0;
        step();
        step();
        chk("cfg_L", umbral_L, 8'd1);
        chk("cfg_H", umbral_H, 8'd6);
        chk("cfg_idle", idle, 1'b1);
        #1 chk("cfg_pop", pop, 4'b0);
        umbral_L_cfg = 8'd3;
        step();
        chk("cfg_L_hold", umbral_L, 8'd1);

        // Plain rotation across four destinations
        vc_empty = 4'h0;
        data_vc  = {12'hC03, 12'h802, 12'h401, 12'h000};
        repeat (5) step();

        // Almost-full head on VC1 is skipped, then granted once the flag clears
        vc_empty         = 4'b1001;
        data_vc          = {12'hC03, 12'h801, 12'b010010100100, 12'h000};
        dest_almost_full = 4'b0010;
        #1 chk("skip_pop", pop, 4'b0100);
        step();
        dest_almost_full = 4'b0000;
        #1 chk("unskip_pop", pop, 4'b0010);
        step();

        // 33 pushes to destination 0 wrap the 5-bit counter to 1
        vc_empty = 4'hF;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        vc_empty = 4'b1110;
        data_vc  = {12'hC03, 12'h801, 12'h402, 12'h0AB};
        repeat (33) step();
        vc_empty = 4'hF;
        step();
        req = 1'b1;
        idx = 3'd0;
        step();
        chk("cnt33", contador, 5'd1);
        chk("cnt33_valid", contador_valid, 1'b1);
        idx = 3'd4;
        step();
        chk("idx4_cnt", contador, 5'd0);
        chk("idx4_valid", contador_valid, 1'b0);
        req = 1'b0;
        step();

        // Reset while a push is pending
        vc_empty = 4'h0;
        data_vc  = {12'hC03, 12'h802, 12'h401, 12'h000};
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("midrst_push", push, 4'b0);
        chk("midrst_idle", idle, 1'b0);
        reset = 1'b0;
        step();
        chk("midrst_init_idle", idle, 1'b0);
        step();
        chk("midrst_reidle", idle, 1'b1);

        // VC0 and VC2 continuously eligible, pointer freshly reset
        vc_empty = 4'b1010;
        data_vc  = {12'hC03, 12'h802, 12'h401, 12'h000};
        for (int i = 0; i < 6; i++) begin
            #1;
`ifdef PRIORIDAD_VC0_EN
            chk("prio_pop", pop, 4'b0001);
`else
            chk("alt_pop", pop, (i % 2 == 0) ? 4'b0001 : 4'b0100);
`endif
            step();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset            = ($urandom_range(0, 63) == 0);
            umbral_L_cfg     = 8'($urandom());
            umbral_H_cfg     = 8'($urandom());
            vc_empty         = 4'($urandom());
            data_vc          = {16'($urandom()), $urandom()};
            dest_almost_full = 4'($urandom()) & 4'($urandom());
            req              = 1'($urandom());
            idx              = 3'($urandom_range(0, 7));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
